// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for an RV32I subset.
// Optional: define ILLEGAL_TRAP_EN to trap illegal encodings (otherwise they retire as NOPs).
module multicycle_control_unit #(
    parameter int unsigned WAIT_MAX  = 15,
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 Znegado,
    input  logic                 mem_ready,
    output logic                 enIR,
    output logic                 enPC,
    output logic                 pcSrc,
    output logic                 enTarget,
    output logic                 enALUout,
    output logic                 selALU_JAL,
    output logic                 selALU_src,
    output logic [2:0]           contALU,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 selAddr,
    output logic                 regWrite,
    output logic [1:0]           selWB,
    output logic [2:0]           state,
    output logic                 mem_err,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } stateT;

    typedef enum logic [2:0] {
        CL_RALU, CL_IALU, CL_LW, CL_SW, CL_BR, CL_JAL, CL_BAD
    } classT;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    stateT      curState;
    classT      clsR;
    logic [2:0] aluR;
    logic       bneR;
    logic [7:0] waitCnt;

    classT      decClass;
    logic [2:0] decAlu;
    logic       decIllegal;
    logic       memWait;
    logic       waitExpire;

    // Opcode fields are decoded live in DECODE (IR just loaded) and latched for later states.
    always_comb begin
        decClass = CL_BAD;
        case (opcode)
            OP_R:    decClass = CL_RALU;
            OP_I:    decClass = CL_IALU;
            OP_LW:   decClass = CL_LW;
            OP_SW:   decClass = CL_SW;
            OP_BR:   decClass = CL_BR;
            OP_JAL:  decClass = CL_JAL;
            default: decClass = CL_BAD;
        endcase

        decAlu = ALU_ADD;
        case (funct3)
            3'b000:  decAlu = (decClass == CL_RALU && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  decAlu = ALU_AND;
            3'b110:  decAlu = ALU_OR;
            3'b100:  decAlu = ALU_XOR;
            3'b010:  decAlu = ALU_SLT;
            3'b001:  decAlu = ALU_SLL;
            3'b101:  decAlu = ALU_SRL;
            default: decAlu = ALU_ADD;
        endcase
        if (decClass == CL_LW || decClass == CL_SW) begin
            decAlu = ALU_ADD;
        end

        decIllegal = (decClass == CL_BAD)
                   || ((decClass == CL_RALU || decClass == CL_IALU) && funct3 == 3'b011)
                   || (decClass == CL_BR && funct3[2:1] != 2'b00);
    end

    assign memWait    = (curState == FETCH || curState == MEM) && !mem_ready;
    assign waitExpire = memWait && (waitCnt == 8'(WAIT_MAX - 1));
    assign state      = curState;

    // Outputs are forced low while reset is asserted, even though FETCH normally strobes memRead.
    always_comb begin
        enIR       = 1'b0;
        enPC       = 1'b0;
        pcSrc      = 1'b0;
        enTarget   = 1'b0;
        enALUout   = 1'b0;
        selALU_JAL = 1'b0;
        selALU_src = 1'b0;
        contALU    = ALU_ADD;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        selAddr    = 1'b0;
        regWrite   = 1'b0;
        selWB      = 2'd0;
        if (rst_n) begin
            case (curState)
                FETCH: begin
                    memRead = 1'b1;
                    enIR    = mem_ready;
                end
                DECODE: begin
                    selALU_JAL = 1'b1;
                    selALU_src = 1'b1;
                    enTarget   = 1'b1;
`ifndef ILLEGAL_TRAP_EN
                    enPC       = decIllegal;
`endif
                end
                EXEC: begin
                    case (clsR)
                        CL_RALU: begin
                            contALU  = aluR;
                            enALUout = 1'b1;
                        end
                        CL_IALU, CL_LW, CL_SW: begin
                            contALU    = aluR;
                            selALU_src = 1'b1;
                            enALUout   = 1'b1;
                        end
                        CL_BR: begin
                            contALU = ALU_SUB;
                            enPC    = 1'b1;
                            pcSrc   = bneR ? Znegado : !Znegado;
                        end
                        CL_JAL: begin
                            regWrite = 1'b1;
                            selWB    = 2'd2;
                            enPC     = 1'b1;
                            pcSrc    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    selAddr  = 1'b1;
                    memRead  = (clsR == CL_LW);
                    memWrite = (clsR == CL_SW);
                    enPC     = (clsR == CL_SW) && mem_ready;
                end
                WB: begin
                    regWrite = 1'b1;
                    selWB    = (clsR == CL_LW) ? 2'd1 : 2'd0;
                    enPC     = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegalR;
    assign illegal = illegalR;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState <= FETCH;
            clsR     <= CL_BAD;
            aluR     <= ALU_ADD;
            bneR     <= 1'b0;
            waitCnt  <= '0;
            instret  <= '0;
            mem_err  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegalR <= 1'b0;
`endif
        end else begin
            if (enPC) begin
                instret <= instret + INSTRET_W'(1);
            end
            waitCnt <= memWait ? waitCnt + 8'd1 : '0;

            case (curState)
                FETCH: begin
                    if (waitExpire) begin
                        mem_err  <= 1'b1;
                        curState <= TRAP;
                    end else if (mem_ready) begin
                        curState <= DECODE;
                    end
                end
                DECODE: begin
                    clsR <= decClass;
                    aluR <= decAlu;
                    bneR <= funct3[0];
                    if (decIllegal) begin
`ifdef ILLEGAL_TRAP_EN
                        illegalR <= 1'b1;
                        curState <= TRAP;
`else
                        curState <= FETCH;
`endif
                    end else begin
                        curState <= EXEC;
                    end
                end
                EXEC: begin
                    case (clsR)
                        CL_RALU, CL_IALU: curState <= WB;
                        CL_LW, CL_SW:     curState <= MEM;
                        default:          curState <= FETCH;
                    endcase
                end
                MEM: begin
                    if (waitExpire) begin
                        mem_err  <= 1'b1;
                        curState <= TRAP;
                    end else if (mem_ready) begin
                        curState <= (clsR == CL_LW) ? WB : FETCH;
                    end
                end
                WB:      curState <= FETCH;
                default: curState <= TRAP;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multicycle control FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It is the initiator side of the Execute stage: it drives selALU_JAL, selALU_src and contALU, and consumes the Znegado flag back for branch resolution. It also drives PC/IR/target/ALU-out register enables, memory strobes and register-file writeback selection for the RV32I subset: R-ALU, I-ALU, LW, SW, BEQ/BNE, JAL.

Parameters:
WAIT_MAX, 15, max consecutive cycles with mem_ready low in FETCH or MEM before mem_err is raised (1..255)
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
Znegado  in  1  Execute flag, 1 when ALU result != 0
mem_ready  in  1  memory completes current access this cycle
enIR  out  1  load IR from memory data
enPC  out  1  load PC
pcSrc  out  1  0 = PC+4, 1 = target register
enTarget  out  1  load target register from resALU
enALUout  out  1  load ALU-out register from resALU
selALU_JAL  out  1  ALU A: 0 = R1, 1 = PC
selALU_src  out  1  ALU B: 0 = R2, 1 = extended immediate
contALU  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
memRead  out  1  read strobe
memWrite  out  1  write strobe
selAddr  out  1  memory address: 0 = PC, 1 = ALU-out
regWrite  out  1  register-file write enable
selWB  out  2  0 = ALU-out, 1 = memory data, 2 = PC+4
state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5
mem_err  out  1  sticky memory timeout
illegal  out  1  sticky illegal instruction (optional feature)
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state=FETCH; all outputs 0; wait counter, instret, mem_err, illegal cleared. Applies mid-instruction; no partial writes are completed.
- Outputs are decoded from state and latched opcode fields. enIR, enPC and the ending transition in FETCH/MEM are additionally gated combinationally by mem_ready.
- FETCH: memRead=1, selAddr=0. When mem_ready=1: enIR=1, go to DECODE. Otherwise stay.
- DECODE: selALU_JAL=1, selALU_src=1, contALU=ADD, enTarget=1 (PC+imm), every instruction. Go to EXEC, or handle illegal (see Optional Feature).
- EXEC:
  - R-type 0110011: src=0; contALU from funct3 (000 ADD, or SUB if funct7_5; 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101 SRL); enALUout=1; go to WB.
  - I-ALU 0010011: same mapping, src=1, funct7_5 ignored; go to WB.
  - LW 0000011 / SW 0100011: ADD, src=1, enALUout=1; go to MEM.
  - BEQ/BNE 1100011 (funct3 000/001): SUB, src=0. Taken = (BEQ & ~Znegado) | (BNE & Znegado). enPC=1, pcSrc=taken; go to FETCH.
  - JAL 1101111: regWrite=1, selWB=2, enPC=1, pcSrc=1; go to FETCH.
- MEM: selAddr=1; memRead (LW) or memWrite (SW) held until mem_ready. On ready: LW goes to WB; SW asserts enPC=1, pcSrc=0, goes to FETCH.
- WB: regWrite=1, selWB=1 for LW else 0; enPC=1, pcSrc=0; go to FETCH.
- Latency with mem_ready always 1: branch/JAL 3 cycles, R/I/SW 4, LW 5.
- instret increments on every cycle where enPC=1 and wraps at 2^INSTRET_W.
- Wait counter: increments each cycle in FETCH/MEM with mem_ready=0 and clears otherwise. On reaching WAIT_MAX: mem_err=1, strobes drop, state=TRAP.
- TRAP: all enables and strobes 0. Exited only by reset.
- Illegal encodings: unknown opcode, funct3=011 on ALU ops, funct3 not 000/001 on branch.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal encoding in DECODE sets illegal=1 (sticky) and goes to TRAP; instret does not increment.
- Undefined: illegal is tied to 0. An illegal instruction is retired as a NOP: DECODE goes directly to FETCH with enPC=1, pcSrc=0, instret+1.

Test Plan:
- add x3,x1,x2 (funct7_5=0), mem_ready=1 -> EXEC contALU=000 src=0; WB regWrite=1 selWB=0; PC+4 after 4 cycles; instret=1.
- beq with Znegado=0, then bne with Znegado=0 -> first pcSrc=1, second pcSrc=0; each enPC pulse 3 cycles after fetch start.
- lw with mem_ready low 3 cycles in MEM -> memRead/selAddr=1 held 4 cycles; WB selWB=1; total 8 cycles.
- jal -> EXEC: regWrite=1, selWB=2, enPC=1, pcSrc=1; DECODE: selALU_JAL=1, selALU_src=1, enTarget=1.
- mem_ready held 0 in FETCH, WAIT_MAX=15 -> mem_err=1, state=TRAP; stays there until rst_n pulse, then FETCH with instret=0.
- opcode 0000000 -> with ILLEGAL_TRAP_EN: illegal=1, TRAP. Without: PC+4 in DECODE, instret+1, no regWrite/memWrite.
